seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider for the measurement-averaging path: divides an accumulated sum by a sample count, one quotient bit per clock.
- Adds unsigned/signed mode, optional round-to-nearest, a valid/ready handshake on both sides, and divide-by-zero and overflow flags.
- Sits between the accumulator and the result/readout logic; one operation in flight at a time.

---
 rtl/seq_divider.sv | 176 +++++++++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Supports unsigned/signed operands, round-to-nearest (half away from zero),
// a valid/ready handshake on both sides, and divide-by-zero / overflow flags.
module seq_divider #(
  parameter  int N  = 65,
  localparam int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_signed,
  input  logic         round_en,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  rem_q, rem_d;     // partial remainder (magnitude)
  logic [2*N-1:0]  dsh_q, dsh_d;     // divisor magnitude, shifted right each step
  logic [N-1:0]    quo_q, quo_d;     // quotient magnitude, built MSB first
  logic [N-1:0]    dmag_q, dmag_d;   // |divisor|, kept for rounding
  logic [N-1:0]    adv_q, adv_d;     // raw dividend, returned on divide by zero
  logic            rnd_q, rnd_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            dz_q, dz_d;
  logic            ov_q, ov_d;
  logic [N-1:0]    qo_q, qo_d;
  logic [N-1:0]    ro_q, ro_d;
  logic            dzo_q, dzo_d;
  logic            ovo_q, ovo_d;
  logic            ovld_q, ovld_d;

  // operand magnitudes; the most negative value maps onto 2^(N-1) unsigned
  logic [N-1:0] amag, bmag;
  assign amag = (is_signed && dividend[N-1]) ? (~dividend + 1'b1) : dividend;
  assign bmag = (is_signed && divisor[N-1])  ? (~divisor + 1'b1)  : divisor;

  // rounding and sign correction on the finished magnitudes
  logic [N-1:0] rm, qm, rmag;
  logic         rnd_hit;
  assign rm      = rem_q[N-1:0];
  assign rnd_hit = rnd_q && ({rm, 1'b0} >= {1'b0, dmag_q});
  assign qm      = quo_q + {{(N-1){1'b0}}, rnd_hit};
  assign rmag    = rnd_hit ? (rm - dmag_q) : rm;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = ovld_q;
  assign quotient    = qo_q;
  assign remainder   = ro_q;
  assign div_by_zero = dzo_q;
  assign overflow    = ovo_q;

  // state register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsh_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      adv_q   <= '0;
      rnd_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      qo_q    <= '0;
      ro_q    <= '0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dsh_q   <= dsh_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      adv_q   <= adv_d;
      rnd_q   <= rnd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dzo_q   <= dzo_d;
      ovo_q   <= ovo_d;
      ovld_q  <= ovld_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dsh_d   = dsh_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    adv_d   = adv_q;
    rnd_d   = rnd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dzo_d   = dzo_q;
    ovo_d   = ovo_q;
    ovld_d  = ovld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = {{N{1'b0}}, amag};
          dsh_d   = {{N{1'b0}}, bmag} << (N-1);
          quo_d   = '0;
          dmag_d  = bmag;
          adv_d   = dividend;
          rnd_d   = round_en;
          negq_d  = is_signed && (dividend[N-1] ^ divisor[N-1]);
          negr_d  = is_signed && dividend[N-1];
          dz_d    = (divisor == '0);
          ov_d    = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) &&
                    (divisor == '1);
        end
      end
      CALC: begin
        // one restoring step: subtract when the shifted divisor fits
        if (rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        dsh_d = dsh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        qo_d    = dz_q ? '1    : (negq_q ? (~qm + 1'b1)   : qm);
        ro_d    = dz_q ? adv_q : (negr_q ? (~rmag + 1'b1) : rmag);
        dzo_d   = dz_q;
        ovo_d   = ov_q && !dz_q;
        ovld_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          dzo_d   = 1'b0;
          ovo_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against an arithmetic model.
module tb_seq_divider;
  localparam int N  = 65;
  localparam int WW = 2*N + 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic         round_en = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_chk  = 0;
  int n_fail = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .round_en(round_en), .dividend(dividend),
    .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: wide signed arithmetic, truncating division, then rounding
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] d,
                       input logic s, input logic rnd,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output logic dz, output logic ov);
    logic signed [WW-1:0] wa, wd, wq, wr, mr, md;
    wa = s ? {{(WW-N){a[N-1]}}, a} : {{(WW-N){1'b0}}, a};
    wd = s ? {{(WW-N){d[N-1]}}, d} : {{(WW-N){1'b0}}, d};
    if (d == '0) begin
      q = '1; r = a; dz = 1'b1; ov = 1'b0;
    end else begin
      wq = wa / wd;
      wr = wa % wd;
      if (rnd) begin
        mr = (wr < 0) ? -wr : wr;
        md = (wd < 0) ? -wd : wd;
        if (2 * mr >= md) begin
          wq = wq + (((wa < 0) != (wd < 0)) ? -1 : 1);
          wr = wa - wq * wd;
        end
      end
      q  = wq[N-1:0];
      r  = wr[N-1:0];
      dz = 1'b0;
      ov = s && (a == {1'b1, {(N-1){1'b0}}}) && (d == '1);
    end
  endtask

  // issue one operation, check latency, result, optional backpressure, handshake
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] d,
                        input logic s, input logic rnd, input int hold);
    logic [N-1:0] eq, er;
    logic edz, eov, busy, moved;
    int edges;
    model(a, d, s, rnd, eq, er, edz, eov);
    edges = 0;
    while (!in_ready && edges < 200) begin @(negedge clk); edges++; end
    chk("in_ready_idle", N'(in_ready), N'(1));
    in_valid = 1'b1; dividend = a; divisor = d; is_signed = s; round_en = rnd;
    @(negedge clk);
    in_valid = 1'b0; dividend = ~a; divisor = a; is_signed = ~s; round_en = ~rnd;
    edges = 0; busy = 1'b0;
    while (!out_valid && edges < 200) begin
      busy |= in_ready;
      @(negedge clk);
      edges++;
    end
    chk("latency", N'(edges), N'(N+1));
    chk("in_ready_busy", N'(busy | in_ready), N'(0));
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", N'(div_by_zero), N'(edz));
    chk("overflow", N'(overflow), N'(eov));
    if (hold > 0) begin
      moved = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!out_valid || quotient !== eq || remainder !== er ||
            div_by_zero !== edz || overflow !== eov || in_ready) moved = 1'b1;
      end
      chk("backpressure_stable", N'(moved), N'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;   // must not be taken on the handshake edge
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_cleared", N'(out_valid), N'(0));
    chk("in_ready_after", N'(in_ready), N'(1));
    chk("flags_cleared", N'({div_by_zero, overflow}), N'(0));
  endtask

  logic [95:0]  rnd96;
  logic [N-1:0] ra, rd;
  logic         rs, rr;

  initial begin
    @(negedge clk);
    chk("reset_out_valid", N'(out_valid), N'(0));
    chk("reset_quotient", quotient, N'(0));
    chk("reset_flags", N'({div_by_zero, overflow}), N'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", N'(in_ready), N'(1));

    run_op(N'(1000000), N'(100000), 1'b0, 1'b0, 0);
    run_op(N'(1234567), N'(100000), 1'b0, 1'b1, 0);
    run_op(N'(1250000), N'(100000), 1'b0, 1'b1, 10);
    run_op(N'(0) - N'(7), N'(2), 1'b1, 1'b0, 0);
    run_op(N'(0) - N'(7), N'(2), 1'b1, 1'b1, 0);
    run_op(N'(7), N'(0) - N'(2), 1'b1, 1'b0, 0);
    run_op(N'(5), N'(0), 1'b0, 1'b0, 0);
    run_op(N'(5), N'(0), 1'b1, 1'b1, 0);
    run_op({1'b1, {(N-1){1'b0}}}, '1, 1'b1, 1'b0, 3);
    run_op({1'b1, {(N-1){1'b0}}}, '1, 1'b1, 1'b1, 0);
    run_op('1, N'(1), 1'b0, 1'b0, 0);

    for (int k = 0; k < 20; k++) begin
      rnd96 = {$urandom, $urandom, $urandom};
      ra = rnd96[N-1:0];
      rnd96 = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       rd = '0;
        1, 2:    rd = N'($urandom_range(1, 1000));
        3:       rd = '1 - N'($urandom_range(0, 50));
        default: rd = rnd96[N-1:0] >> $urandom_range(0, 40);
      endcase
      rs = 1'(($urandom & 1));
      rr = 1'(($urandom & 1));
      run_op(ra, rd, rs, rr, k % 3);
    end

    // reset in the middle of CALC abandons the operation
    in_valid = 1'b1; dividend = N'(999); divisor = N'(10);
    is_signed = 1'b0; round_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", N'(out_valid), N'(0));
    chk("midreset_quotient", quotient, N'(0));
    chk("midreset_remainder", remainder, N'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_in_ready", N'(in_ready), N'(1));
    run_op(N'(100), N'(7), 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
